register_write_arbiter: RTL and testbench

REGISTER_WRITE_ARBITER -- requirements
Module: register_write_arbiter

---
 rtl/register_file_pkg.sv | 24 ++
 rtl/round_robin_arbiter_2.sv | 50 +++++
 rtl/register_write_arbiter.sv | 105 ++++++++++
 tb/tb_register_write_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_pkg
// Description : Shared widths and enums for the register-file write path.
// Revision    : 1.0
// ============================================================================
package register_file_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int REG_COUNT = 32;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        SRC_ALU    = 1'b0,
        SRC_MEMORY = 1'b1
    } src_t;

endpackage
`default_nettype wire

// File: rtl/round_robin_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_arbiter_2
// Description : Two-way round-robin grant; pointer moves on accepted grants.
// Revision    : 1.0
// ============================================================================
module round_robin_arbiter_2
    import register_file_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_enable,
    input  logic i_req_alu,
    input  logic i_req_mem,
    output logic o_gnt_alu,
    output logic o_gnt_mem
);

    src_t r_last;

    always_comb begin
        o_gnt_alu = 1'b0;
        o_gnt_mem = 1'b0;
        if (i_enable) begin
            if (i_req_alu && i_req_mem) begin
                if (r_last == SRC_ALU) begin
                    o_gnt_mem = 1'b1;
                end else begin
                    o_gnt_alu = 1'b1;
                end
            end else begin
                o_gnt_alu = i_req_alu;
                o_gnt_mem = i_req_mem;
            end
        end
    end

    // A grant is only ever issued to a requesting source, so a grant is a handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= SRC_ALU;
        end else if (o_gnt_alu) begin
            r_last <= SRC_ALU;
        end else if (o_gnt_mem) begin
            r_last <= SRC_MEMORY;
        end
    end

endmodule
`default_nettype wire

// File: rtl/register_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : register_write_arbiter
// Description : Zeroes the register file after reset, then arbitrates ALU and
//               load-unit writebacks into one registered write port.
// Revision    : 1.0
// ============================================================================
module register_write_arbiter
    import register_file_pkg::*;
#(
    parameter logic INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_write_valid,
    output logic              alu_write_ready,
    input  logic [ADDR_W-1:0] alu_write_address,
    input  logic [DATA_W-1:0] alu_write_data,
    input  logic              memory_write_valid,
    output logic              memory_write_ready,
    input  logic [ADDR_W-1:0] memory_write_address,
    input  logic [DATA_W-1:0] memory_write_data,
    output logic              register_write_enable,
    output logic [ADDR_W-1:0] register_write_address,
    output logic [DATA_W-1:0] register_write_data,
    output logic              init_done
);

    localparam state_t            c_RESET_STATE = (INIT_CLEAR != 1'b0) ? INIT : RUN;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR   = ADDR_W'(REG_COUNT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_run;
    logic              w_gnt_alu;
    logic              w_gnt_mem;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    // Gated with reset_n so readies and init_done drop the instant reset asserts,
    // including the INIT_CLEAR=0 case where the reset state is already RUN.
    assign w_run = (r_state == RUN) && reset_n;

    round_robin_arbiter_2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_enable  (w_run),
        .i_req_alu (alu_write_valid),
        .i_req_mem (memory_write_valid),
        .o_gnt_alu (w_gnt_alu),
        .o_gnt_mem (w_gnt_mem)
    );

    always_comb begin
        w_next_state = r_state;
        if ((r_state == INIT) && (r_count == c_LAST_ADDR)) begin
            w_next_state = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_sel_addr = w_gnt_alu ? alu_write_address : memory_write_address;
    assign w_sel_data = w_gnt_alu ? alu_write_data    : memory_write_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (r_state == INIT) begin
            r_we    <= 1'b1;
            r_waddr <= r_count;
            r_wdata <= '0;
            r_count <= r_count + 1'b1;
        end else if (w_gnt_alu || w_gnt_mem) begin
            // x0 is hardwired to zero: accept the write but suppress the strobe.
            r_we    <= (w_sel_addr != '0);
            r_waddr <= w_sel_addr;
            r_wdata <= w_sel_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign alu_write_ready        = w_gnt_alu;
    assign memory_write_ready     = w_gnt_mem;
    assign register_write_enable  = r_we;
    assign register_write_address = r_waddr;
    assign register_write_data    = r_wdata;
    assign init_done              = w_run;

endmodule
`default_nettype wire

// File: tb/tb_register_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_write_arbiter
// Description : Directed bench with a cycle-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_register_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_v = 1'b0;
    logic [4:0]  alu_a = '0;
    logic [31:0] alu_d = '0;
    logic        mem_v = 1'b0;
    logic [4:0]  mem_a = '0;
    logic [31:0] mem_d = '0;
    logic        b_alu_v = 1'b0;

    wire         alu_rdy, mem_rdy, we, idone;
    wire  [4:0]  waddr;
    wire  [31:0] wdata;
    wire         b_alu_rdy, b_mem_rdy, b_we, b_idone;
    wire  [4:0]  b_waddr;
    wire  [31:0] b_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    register_write_arbiter #(.INIT_CLEAR(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_write_valid(alu_v), .alu_write_ready(alu_rdy),
        .alu_write_address(alu_a), .alu_write_data(alu_d),
        .memory_write_valid(mem_v), .memory_write_ready(mem_rdy),
        .memory_write_address(mem_a), .memory_write_data(mem_d),
        .register_write_enable(we), .register_write_address(waddr),
        .register_write_data(wdata), .init_done(idone)
    );

    register_write_arbiter #(.INIT_CLEAR(1'b0)) dut_noclr (
        .clk(clk), .reset_n(reset_n),
        .alu_write_valid(b_alu_v), .alu_write_ready(b_alu_rdy),
        .alu_write_address(alu_a), .alu_write_data(alu_d),
        .memory_write_valid(1'b0), .memory_write_ready(b_mem_rdy),
        .memory_write_address(mem_a), .memory_write_data(mem_d),
        .register_write_enable(b_we), .register_write_address(b_waddr),
        .register_write_data(b_wdata), .init_done(b_idone)
    );

    // Reference model: edges since reset drive the sweep, m_last_mem remembers
    // who won the most recent handshake.
    int          m_edges = 0;
    logic        m_last_mem = 1'b0;
    logic        m_we = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    wire         m_run = reset_n && (m_edges >= 32);
    wire         exp_ga = m_run && alu_v && (!mem_v || m_last_mem);
    wire         exp_gm = m_run && mem_v && (!alu_v || !m_last_mem);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_edges    <= 0;
            m_last_mem <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_data     <= '0;
        end else if (m_edges < 32) begin
            m_we    <= 1'b1;
            m_addr  <= m_edges[4:0];
            m_data  <= '0;
            m_edges <= m_edges + 1;
        end else if (exp_ga) begin
            m_we       <= (alu_a != 5'd0);
            m_addr     <= alu_a;
            m_data     <= alu_d;
            m_last_mem <= 1'b0;
        end else if (exp_gm) begin
            m_we       <= (mem_a != 5'd0);
            m_addr     <= mem_a;
            m_data     <= mem_d;
            m_last_mem <= 1'b1;
        end else begin
            m_we <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model alu_ready", {31'd0, alu_rdy}, {31'd0, exp_ga});
            chk("model mem_ready", {31'd0, mem_rdy}, {31'd0, exp_gm});
            chk("model init_done", {31'd0, idone}, {31'd0, m_run});
            chk("model write_enable", {31'd0, we}, {31'd0, m_we});
            if (m_we) begin
                chk("model write_address", {27'd0, waddr}, {27'd0, m_addr});
                chk("model write_data", wdata, m_data);
            end
        end
    end

    task automatic run_sweep(input int last);
        for (int i = 0; i <= last; i++) begin
            @(posedge clk);
            #1;
            alu_v = (i >= 3 && i <= 8);
            mem_v = (i >= 5 && i <= 9);
            @(negedge clk);
            chk("sweep enable", {31'd0, we}, 32'd1);
            chk("sweep address", {27'd0, waddr}, i);
            chk("sweep data", wdata, 32'd0);
            chk("sweep init_done", {31'd0, idone}, (i == 31) ? 32'd1 : 32'd0);
            chk("sweep readies", {30'd0, alu_rdy, mem_rdy}, 32'd0);
        end
    endtask

    logic exp_mem_first [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        alu_v   = 1'b1;
        b_alu_v = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset enable", {31'd0, we}, 32'd0);
        chk("reset address", {27'd0, waddr}, 32'd0);
        chk("reset data", wdata, 32'd0);
        chk("reset init_done", {31'd0, idone}, 32'd0);
        chk("reset alu_ready", {31'd0, alu_rdy}, 32'd0);
        chk("noclr reset init_done", {31'd0, b_idone}, 32'd0);
        chk("noclr reset alu_ready", {31'd0, b_alu_rdy}, 32'd0);

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        alu_v   = 1'b0;
        #1;
        chk("noclr init_done", {31'd0, b_idone}, 32'd1);
        chk("noclr ready follows valid hi", {31'd0, b_alu_rdy}, 32'd1);
        b_alu_v = 1'b0;
        #1;
        chk("noclr ready follows valid lo", {31'd0, b_alu_rdy}, 32'd0);

        run_sweep(31);

        @(posedge clk);
        #1;
        alu_v = 1'b1; alu_a = 5'd5; alu_d = 32'hDEADBEEF;
        @(negedge clk);
        chk("alu only ready", {30'd0, alu_rdy, mem_rdy}, 32'd2);
        @(posedge clk);
        #1;
        alu_v = 1'b0;
        @(negedge clk);
        chk("alu write enable", {31'd0, we}, 32'd1);
        chk("alu write address", {27'd0, waddr}, 32'd5);
        chk("alu write data", wdata, 32'hDEADBEEF);

        @(posedge clk);
        #1;
        alu_v = 1'b1; alu_a = 5'd1; alu_d = 32'h1111_1111;
        mem_v = 1'b1; mem_a = 5'd2; mem_d = 32'h2222_2222;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                chk("contention grant", {30'd0, alu_rdy, mem_rdy},
                    exp_mem_first[i] ? 32'd1 : 32'd2);
            end
            if (i > 0) begin
                chk("contention write address", {27'd0, waddr},
                    exp_mem_first[i-1] ? 32'd2 : 32'd1);
                chk("contention write data", wdata,
                    exp_mem_first[i-1] ? 32'h2222_2222 : 32'h1111_1111);
            end
            @(posedge clk);
            #1;
            if (i == 3) begin
                alu_v = 1'b0;
                mem_v = 1'b0;
            end
        end

        mem_v = 1'b1; mem_a = 5'd0; mem_d = 32'h1234_5678;
        @(negedge clk);
        chk("x0 write mem_ready", {30'd0, alu_rdy, mem_rdy}, 32'd1);
        @(posedge clk);
        #1;
        mem_v = 1'b0;
        @(negedge clk);
        chk("x0 write enable", {31'd0, we}, 32'd0);

        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_sweep(10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid-sweep reset enable", {31'd0, we}, 32'd0);
        chk("mid-sweep reset address", {27'd0, waddr}, 32'd0);
        chk("mid-sweep reset data", wdata, 32'd0);
        chk("mid-sweep reset init_done", {31'd0, idone}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_sweep(31);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
